pipe_data_path: RTL and testbench

PIPE_DATA_PATH -- requirements
Module: pipe_data_path

---
 rtl/dp_pkg.sv | 32 +++
 rtl/reg_file_p.sv | 36 +++
 rtl/pipe_data_path.sv | 161 ++++++++++++++++
 tb/tb_pipe_data_path.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// Shared encodings for the pipelined datapath: ALU ops, write-back source, flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dp_pkg;

    // ALU operation select (AddSub port)
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    // Write-back source select (destSrc port)
    typedef enum logic [1:0] {
        DS_DATA = 2'b00,
        DS_RY   = 2'b01,
        DS_ALU  = 2'b10,
        DS_NONE = 2'b11
    } dest_src_e;

    // Bit positions inside the {N,V,C,Z} flags vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/reg_file_p.sv
// General register file: two asynchronous read ports, one synchronous write port.
// Latency: reads combinational, write visible the cycle after i_we.
// Backpressure: none; the caller decides when to write.
module reg_file_p #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    i_raddr_a,
    input  logic [AW-1:0]    i_raddr_b,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [NREGS];

    // Storage: reset wins over a same-edge write so a discarded instruction never lands
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/pipe_data_path.sv
// Two-stage datapath: issue/execute (operand read + forward, ALU, source mux) then a write-back register.
// Latency: 1 cycle from acceptance to out_valid; commit to registers/flags on the out handshake.
// Backpressure: in_ready = !out_valid || out_ready; WB holds steady while the consumer stalls.
module pipe_data_path
    import dp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataIn,
    input  logic [AW-1:0]    Rx,
    input  logic [AW-1:0]    Ry,
    input  logic [2:0]       AddSub,
    input  logic [1:0]       destSrc,
    output logic [WIDTH-1:0] dataOut,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    // Write-back stage state
    logic             r_out_valid;
    logic [WIDTH-1:0] r_wb_val;
    logic [AW-1:0]    r_wb_rx;
    logic             r_wb_we;
    logic             r_wb_fupd;
    logic [3:0]       r_wb_flags;
    logic [3:0]       r_flags;

    logic             w_accept;
    logic             w_commit;
    logic [WIDTH-1:0] w_rf_a;
    logic [WIDTH-1:0] w_rf_b;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_alu_flags;
    logic [WIDTH-1:0] w_wb_val_nxt;
    logic             w_we_nxt;
    logic             w_fupd_nxt;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_commit = r_out_valid && out_ready;

    reg_file_p #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_rf (
        .clock     (clock),
        .reset     (reset),
        .i_raddr_a (Rx),
        .i_raddr_b (Ry),
        .i_we      (w_commit && r_wb_we),
        .i_waddr   (r_wb_rx),
        .i_wdata   (r_wb_val),
        .o_rdata_a (w_rf_a),
        .o_rdata_b (w_rf_b)
    );

    // Uncommitted WB result bypasses the register file for either operand
    assign w_opa = (r_out_valid && r_wb_we && (r_wb_rx == Rx)) ? r_wb_val : w_rf_a;
    assign w_opb = (r_out_valid && r_wb_we && (r_wb_rx == Ry)) ? r_wb_val : w_rf_b;

    // ALU: SUB is a + ~b + 1 so the carry-out is directly NOT-borrow
    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (alu_op_e'(AddSub))
            OP_ADD: begin
                w_sum = {1'b0, w_opa} + {1'b0, w_opb};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_opa[MSB] == w_opb[MSB]) && (w_res[MSB] != w_opa[MSB]);
            end
            OP_SUB: begin
                w_sum = {1'b0, w_opa} + {1'b0, ~w_opb} + (WIDTH+1)'(1);
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_opa[MSB] != w_opb[MSB]) && (w_res[MSB] != w_opa[MSB]);
            end
            OP_AND: w_res = w_opa & w_opb;
            OP_OR:  w_res = w_opa | w_opb;
            OP_XOR: w_res = w_opa ^ w_opb;
            OP_NOT: w_res = ~w_opb;
            OP_SHL: begin
                w_res = {w_opa[MSB-1:0], 1'b0};
                w_c   = w_opa[MSB];
            end
            OP_SHR: begin
                w_res = {1'b0, w_opa[MSB:1]};
                w_c   = w_opa[0];
            end
        endcase
    end

    always_comb begin
        w_alu_flags         = '0;
        w_alu_flags[FLAG_N] = w_res[MSB];
        w_alu_flags[FLAG_V] = w_v;
        w_alu_flags[FLAG_C] = w_c;
        w_alu_flags[FLAG_Z] = (w_res == '0);
    end

    // Write-back source select; DS_NONE just echoes Rx without touching state
    always_comb begin
        w_wb_val_nxt = w_opa;
        w_we_nxt     = 1'b0;
        w_fupd_nxt   = 1'b0;
        case (dest_src_e'(destSrc))
            DS_DATA: begin w_wb_val_nxt = dataIn; w_we_nxt = 1'b1; end
            DS_RY:   begin w_wb_val_nxt = w_opb;  w_we_nxt = 1'b1; end
            DS_ALU:  begin w_wb_val_nxt = w_res;  w_we_nxt = 1'b1; w_fupd_nxt = 1'b1; end
            DS_NONE: begin w_wb_val_nxt = w_opa; end
        endcase
    end

    // WB register and committed flags; a new acceptance replaces WB on the same edge the old one commits
    always_ff @(posedge clock) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_wb_val    <= '0;
            r_wb_rx     <= '0;
            r_wb_we     <= 1'b0;
            r_wb_fupd   <= 1'b0;
            r_wb_flags  <= '0;
            r_flags     <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_wb_val    <= w_wb_val_nxt;
                r_wb_rx     <= Rx;
                r_wb_we     <= w_we_nxt;
                r_wb_fupd   <= w_fupd_nxt;
                r_wb_flags  <= w_alu_flags;
            end else if (w_commit) begin
                r_out_valid <= 1'b0;
            end
            if (w_commit && r_wb_fupd) begin
                r_flags <= r_wb_flags;
            end
        end
    end

    assign dataOut   = r_wb_val;
    assign out_valid = r_out_valid;
    assign flags     = r_flags;

endmodule

// File: tb/tb_pipe_data_path.sv
// Directed bench for pipe_data_path: vector table streamed back-to-back, then stall and reset sequences.
module tb_pipe_data_path;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dataIn;
    logic [2:0] Rx;
    logic [2:0] Ry;
    logic [2:0] AddSub;
    logic [1:0] destSrc;
    logic [7:0] dataOut;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] flags;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;

    pipe_data_path #(
        .WIDTH (8),
        .NREGS (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataIn    (dataIn),
        .Rx        (Rx),
        .Ry        (Ry),
        .AddSub    (AddSub),
        .destSrc   (destSrc),
        .dataOut   (dataOut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flags     (flags)
    );

    always #5 clock = ~clock;

    // Output handshakes seen at each rising edge (pre-update values)
    always @(posedge clock) begin
        if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic [7:0] din;
        logic [2:0] rx;
        logic [2:0] ry;
        logic [2:0] op;
        logic [1:0] ds;
        logic [7:0] dout;
        logic [3:0] fl;   // {N,V,C,Z} once this instruction has committed
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic drive(input logic v, input logic [7:0] din, input logic [2:0] rx,
                         input logic [2:0] ry, input logic [2:0] op, input logic [1:0] ds);
        in_valid = v;
        dataIn   = din;
        Rx       = rx;
        Ry       = ry;
        AddSub   = op;
        destSrc  = ds;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_fl;
        int hs0;

        //           din    rx    ry    op      ds     dout   fl
        vecs[0]  = '{8'h05, 3'd1, 3'd0, 3'b000, 2'b00, 8'h05, 4'h0}; // R1 = 05
        vecs[1]  = '{8'h03, 3'd2, 3'd0, 3'b000, 2'b00, 8'h03, 4'h0}; // R2 = 03
        vecs[2]  = '{8'h00, 3'd1, 3'd2, 3'b000, 2'b10, 8'h08, 4'h0}; // ADD R1,R2 (R2 forwarded)
        vecs[3]  = '{8'hFF, 3'd1, 3'd0, 3'b000, 2'b00, 8'hFF, 4'h0}; // R1 = FF
        vecs[4]  = '{8'h00, 3'd1, 3'd1, 3'b000, 2'b10, 8'hFE, 4'hA}; // ADD R1,R1 fwd: N,C
        vecs[5]  = '{8'h80, 3'd3, 3'd0, 3'b000, 2'b00, 8'h80, 4'hA}; // R3 = 80
        vecs[6]  = '{8'h01, 3'd4, 3'd0, 3'b000, 2'b00, 8'h01, 4'hA}; // R4 = 01
        vecs[7]  = '{8'h00, 3'd3, 3'd4, 3'b001, 2'b10, 8'h7F, 4'h6}; // SUB R3,R4: V,C
        vecs[8]  = '{8'h00, 3'd1, 3'd1, 3'b001, 2'b10, 8'h00, 4'h3}; // SUB R1,R1: C,Z
        vecs[9]  = '{8'h00, 3'd2, 3'd0, 3'b000, 2'b11, 8'h03, 4'h3}; // read R2, flags kept
        vecs[10] = '{8'h00, 3'd1, 3'd0, 3'b000, 2'b11, 8'h00, 4'h3}; // read R1
        vecs[11] = '{8'h00, 3'd3, 3'd4, 3'b010, 2'b10, 8'h01, 4'h0}; // AND 7F&01
        vecs[12] = '{8'h00, 3'd4, 3'd1, 3'b011, 2'b10, 8'h01, 4'h0}; // OR 01|00
        vecs[13] = '{8'h00, 3'd4, 3'd4, 3'b100, 2'b10, 8'h00, 4'h1}; // XOR R4,R4: Z
        vecs[14] = '{8'h00, 3'd5, 3'd4, 3'b101, 2'b10, 8'hFF, 4'h8}; // NOT R4 -> R5
        vecs[15] = '{8'h00, 3'd5, 3'd0, 3'b110, 2'b10, 8'hFE, 4'hA}; // SHL FF: C out
        vecs[16] = '{8'h00, 3'd5, 3'd0, 3'b111, 2'b10, 8'h7F, 4'h0}; // SHR FE: C=0
        vecs[17] = '{8'h00, 3'd4, 3'd0, 3'b111, 2'b10, 8'h00, 4'h1}; // SHR 00: Z
        vecs[18] = '{8'h00, 3'd0, 3'd5, 3'b000, 2'b01, 8'h7F, 4'h1}; // R0 = R5
        vecs[19] = '{8'h00, 3'd0, 3'd0, 3'b000, 2'b11, 8'h7F, 4'h1}; // read R0 (forwarded)
        vecs[20] = '{8'h80, 3'd7, 3'd0, 3'b000, 2'b00, 8'h80, 4'h1}; // R7 = 80
        vecs[21] = '{8'h00, 3'd7, 3'd7, 3'b000, 2'b10, 8'h00, 4'h7}; // ADD 80+80: V,C,Z
        vecs[22] = '{8'h00, 3'd7, 3'd0, 3'b000, 2'b11, 8'h00, 4'h7}; // read R7

        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 3'd0, 3'd0, 3'b000, 2'b00);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset dataOut",   32'(dataOut),   32'h00);
        chk("reset flags",     32'(flags),     32'h0);
        chk("reset in_ready",  32'(in_ready),  32'd1);

        // Back-to-back stream: check WB result and flags of the previous instruction
        prev_fl = 4'h0;
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, vecs[i].din, vecs[i].rx, vecs[i].ry, vecs[i].op, vecs[i].ds);
            @(negedge clock);
            chk($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'd1);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d dataOut", i),   32'(dataOut),   32'(vecs[i].dout));
            chk($sformatf("vec%0d flags", i),     32'(flags),     32'(prev_fl));
            prev_fl = vecs[i].fl;
        end
        drive(1'b0, 8'h00, 3'd0, 3'd0, 3'b000, 2'b00);
        @(negedge clock);
        chk("drain out_valid", 32'(out_valid), 32'd0);
        chk("drain flags",     32'(flags),     32'(prev_fl));

        // Stall: consumer holds off for 3 cycles while the next instruction waits
        out_ready = 1'b0;
        drive(1'b1, 8'h33, 3'd6, 3'd0, 3'b000, 2'b00);
        @(negedge clock);
        hs0 = hs_cnt;
        chk("stall first dataOut", 32'(dataOut),  32'h33);
        chk("stall first in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h44, 3'd6, 3'd0, 3'b000, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk($sformatf("stall%0d in_ready", k),  32'(in_ready),  32'd0);
            chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d dataOut", k),   32'(dataOut),   32'h33);
        end
        out_ready = 1'b1;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        chk("release dataOut",   32'(dataOut),   32'h44);
        chk("release out_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 8'h00, 3'd0, 3'd0, 3'b000, 2'b00);
        @(negedge clock);
        chk("stall drained",    32'(out_valid),    32'd0);
        chk("stall commits",    32'(hs_cnt - hs0), 32'd2);
        drive(1'b1, 8'h00, 3'd6, 3'd0, 3'b000, 2'b11);
        @(negedge clock);
        chk("stall R6", 32'(dataOut), 32'h44);
        drive(1'b0, 8'h00, 3'd0, 3'd0, 3'b000, 2'b00);
        @(negedge clock);

        // Reset while WB holds an uncommitted load of 55 into R5
        out_ready = 1'b0;
        drive(1'b1, 8'h55, 3'd5, 3'd0, 3'b000, 2'b00);
        @(negedge clock);
        chk("pre-reset dataOut", 32'(dataOut), 32'h55);
        drive(1'b0, 8'h00, 3'd0, 3'd0, 3'b000, 2'b00);
        out_ready = 1'b1;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid-reset out_valid", 32'(out_valid), 32'd0);
        chk("mid-reset dataOut",   32'(dataOut),   32'h00);
        chk("mid-reset flags",     32'(flags),     32'h0);
        chk("mid-reset in_ready",  32'(in_ready),  32'd1);
        drive(1'b1, 8'h00, 3'd5, 3'd0, 3'b000, 2'b11);
        @(negedge clock);
        chk("mid-reset R5", 32'(dataOut), 32'h00);
        drive(1'b1, 8'h00, 3'd0, 3'd0, 3'b000, 2'b11);
        @(negedge clock);
        chk("mid-reset R0", 32'(dataOut), 32'h00);
        drive(1'b0, 8'h00, 3'd0, 3'd0, 3'b000, 2'b00);
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
